// File: rtl/membus_arbiter.sv
//==============================================================================
// Module   : membus_arbiter
// Brief    : Single-port memory arbiter sharing one bus between fetch and
//            load/store, with bounded fetch starvation and access timeout.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module membus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_WAIT   = 15,
    parameter int STARVE_LIM = 4
) (
    input  logic              i_clk,
    input  logic              i_nreset,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              o_d_gnt,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ready,
    output logic              o_bus_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam int                    c_STARVE_W   = $clog2(STARVE_LIM + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIM);
    localparam logic [c_STARVE_W-1:0] c_STARVE_ONE = c_STARVE_W'(1);
    localparam logic [7:0]            c_WAIT_LAST  = 8'(MAX_WAIT - 1);

    state_t                state_q, state_d;
    logic                  own_data_q, own_data_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic                  if_gnt_q, if_gnt_d;
    logic                  d_gnt_q, d_gnt_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]     d_rdata_q, d_rdata_d;
    logic [c_STARVE_W-1:0] starve_q, starve_d;
    logic [7:0]            wait_q, wait_d;

    logic w_pick_data;

    // Data has priority unless fetch has already been passed over STARVE_LIM times.
    assign w_pick_data = i_d_req && !(i_if_req && (starve_q == c_STARVE_MAX));

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            state_q    <= S_IDLE;
            own_data_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            if_gnt_q   <= 1'b0;
            d_gnt_q    <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            starve_q   <= '0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            own_data_q <= own_data_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            if_gnt_q   <= if_gnt_d;
            d_gnt_q    <= d_gnt_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            starve_q   <= starve_d;
            wait_q     <= wait_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        own_data_d = own_data_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        if_gnt_d   = 1'b0;
        d_gnt_d    = 1'b0;
        err_d      = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        starve_d   = starve_q;
        wait_d     = wait_q;

        unique case (state_q)
            S_IDLE: begin
                if (w_pick_data) begin
                    own_data_d = 1'b1;
                    addr_d     = i_d_addr;
                    wdata_d    = i_d_wdata;
                    rd_d       = !i_d_we;
                    wr_d       = i_d_we;
                    wait_d     = '0;
                    state_d    = S_ACCESS;
                    if (i_if_req && (starve_q != c_STARVE_MAX)) begin
                        starve_d = starve_q + c_STARVE_ONE;
                    end
                end else if (i_if_req) begin
                    own_data_d = 1'b0;
                    addr_d     = i_if_addr;
                    rd_d       = 1'b1;
                    wr_d       = 1'b0;
                    wait_d     = '0;
                    starve_d   = '0;
                    state_d    = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Grant and error are registered on the way into RESP so they
                // are visible for exactly the RESP cycle.
                if (i_mem_ready) begin
                    if (rd_q && own_data_q) begin
                        d_rdata_d = i_mem_rdata;
                    end else if (rd_q) begin
                        if_rdata_d = i_mem_rdata;
                    end
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    if_gnt_d = !own_data_q;
                    d_gnt_d  = own_data_q;
                    state_d  = S_RESP;
                end else if (wait_q == c_WAIT_LAST) begin
                    if (rd_q && own_data_q) begin
                        d_rdata_d = '1;
                    end else if (rd_q) begin
                        if_rdata_d = '1;
                    end
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    err_d    = 1'b1;
                    if_gnt_d = !own_data_q;
                    d_gnt_d  = own_data_q;
                    state_d  = S_RESP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_if_gnt    = if_gnt_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_d_gnt     = d_gnt_q;
    assign o_d_rdata   = d_rdata_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_read  = rd_q;
    assign o_mem_write = wr_q;
    assign o_mem_wdata = wdata_q;
    assign o_bus_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_membus_arbiter.sv
//==============================================================================
// Module   : tb_membus_arbiter
// Brief    : Directed self-checking bench for membus_arbiter with a
//            transaction-level reference model compared every cycle.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_membus_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MAX_WAIT   = 15;
    localparam int STARVE_LIM = 4;

    logic              clk = 1'b0;
    logic              nreset = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ready = 1'b0;
    logic              o_if_gnt, o_d_gnt, o_mem_read, o_mem_write, o_bus_err;
    logic [DATA_W-1:0] o_if_rdata, o_d_rdata, o_mem_wdata;
    logic [ADDR_W-1:0] o_mem_addr;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory responder knobs
    logic [DATA_W-1:0] rd_value = '0;
    int                ready_delay = 0;
    bit                junk_ready = 1'b0;
    int                sc = 0;

    // Monitor records
    int                rd_total = 0;
    int                wr_total = 0;
    bit                prev_strobe = 1'b0;
    logic [ADDR_W-1:0] acc_q[$];
    bit                gnt_log[$];

    // Reference model: one transfer at a time, each a strobe phase followed by
    // a single response cycle.
    bit                m_xfer = 0, m_resp = 0, m_own_d = 0, m_to = 0;
    int                m_left = 0, m_dstreak = 0;
    logic              m_read = 0, m_write = 0, m_if_gnt = 0, m_d_gnt = 0, m_err = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_wdata = '0, m_if_rdata = '0, m_d_rdata = '0;

    always #5 clk = ~clk;

    membus_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_WAIT  (MAX_WAIT),
        .STARVE_LIM(STARVE_LIM)
    ) dut (
        .i_clk      (clk),
        .i_nreset   (nreset),
        .i_if_req   (if_req),
        .i_if_addr  (if_addr),
        .o_if_gnt   (o_if_gnt),
        .o_if_rdata (o_if_rdata),
        .i_d_req    (d_req),
        .i_d_we     (d_we),
        .i_d_addr   (d_addr),
        .i_d_wdata  (d_wdata),
        .o_d_gnt    (o_d_gnt),
        .o_d_rdata  (o_d_rdata),
        .o_mem_addr (o_mem_addr),
        .o_mem_read (o_mem_read),
        .o_mem_write(o_mem_write),
        .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(mem_rdata),
        .i_mem_ready(mem_ready),
        .o_bus_err  (o_bus_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_gnt(input bit data, input int limit, output int cycles);
        bit hit;
        hit    = 1'b0;
        cycles = 0;
        while (!hit && cycles < limit) begin
            step();
            cycles++;
            hit = data ? o_d_gnt : o_if_gnt;
        end
        check("grant_within_bound", {31'd0, hit}, 32'd1);
    endtask

    initial begin
        int               c, s_rd, s_wr, g0, a0, grants;
        logic [9:0]       order;
        logic [DATA_W-1:0] want_pattern;

        fork
            // Reference model
            forever begin
                @(posedge clk or negedge nreset);
                if (!nreset) begin
                    m_xfer = 0; m_resp = 0; m_own_d = 0; m_left = 0; m_dstreak = 0;
                    m_read = 0; m_write = 0; m_if_gnt = 0; m_d_gnt = 0; m_err = 0;
                    m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0;
                end else begin
                    m_if_gnt = 0; m_d_gnt = 0; m_err = 0;
                    if (m_xfer) begin
                        if (mem_ready || m_left == 1) begin
                            m_to = !mem_ready;
                            if (m_read) begin
                                if (m_own_d) m_d_rdata  = m_to ? '1 : mem_rdata;
                                else         m_if_rdata = m_to ? '1 : mem_rdata;
                            end
                            m_read = 0; m_write = 0; m_err = m_to;
                            if (m_own_d) m_d_gnt = 1; else m_if_gnt = 1;
                            m_xfer = 0; m_resp = 1;
                        end else begin
                            m_left = m_left - 1;
                        end
                    end else if (m_resp) begin
                        m_resp = 0;
                    end else if (d_req && !(if_req && m_dstreak >= STARVE_LIM)) begin
                        m_own_d = 1; m_addr = d_addr; m_wdata = d_wdata;
                        m_read = !d_we; m_write = d_we;
                        m_xfer = 1; m_left = MAX_WAIT;
                        if (if_req && m_dstreak < STARVE_LIM) m_dstreak++;
                    end else if (if_req) begin
                        m_own_d = 0; m_addr = if_addr; m_read = 1; m_write = 0;
                        m_xfer = 1; m_left = MAX_WAIT; m_dstreak = 0;
                    end
                end
            end
            // Memory responder
            forever begin
                @(posedge clk);
                #2;
                mem_rdata = rd_value;
                if (o_mem_read || o_mem_write) begin
                    mem_ready = (ready_delay >= 0) && (sc == ready_delay);
                    sc++;
                end else begin
                    sc        = 0;
                    mem_ready = junk_ready;
                end
            end
            // Bus monitor
            forever begin
                @(negedge clk);
                if (o_mem_read)  rd_total++;
                if (o_mem_write) wr_total++;
                if ((o_mem_read || o_mem_write) && !prev_strobe) acc_q.push_back(o_mem_addr);
                prev_strobe = o_mem_read || o_mem_write;
                if (o_if_gnt) gnt_log.push_back(1'b0);
                if (o_d_gnt)  gnt_log.push_back(1'b1);
            end
            // Cycle compare against the model
            forever begin
                @(negedge clk);
                check("mem_read",  {31'd0, o_mem_read},  {31'd0, m_read});
                check("mem_write", {31'd0, o_mem_write}, {31'd0, m_write});
                check("mem_addr",  o_mem_addr,  m_addr);
                check("mem_wdata", o_mem_wdata, m_wdata);
                check("if_gnt",    {31'd0, o_if_gnt},    {31'd0, m_if_gnt});
                check("d_gnt",     {31'd0, o_d_gnt},     {31'd0, m_d_gnt});
                check("bus_err",   {31'd0, o_bus_err},   {31'd0, m_err});
                check("if_rdata",  o_if_rdata, m_if_rdata);
                check("d_rdata",   o_d_rdata,  m_d_rdata);
            end
            // Watchdog
            begin
                #200000;
                $display("FAIL watchdog: got timeout, want completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state
        repeat (3) step();
        check("rst_strobes_gnts", {27'd0, o_mem_read, o_mem_write, o_if_gnt, o_d_gnt, o_bus_err}, 32'd0);
        check("rst_mem_addr", o_mem_addr, 32'd0);
        check("rst_mem_wdata", o_mem_wdata, 32'd0);
        check("rst_rdata", o_if_rdata | o_d_rdata, 32'd0);
        nreset = 1'b1;
        step();

        // Single fetch, immediate ready
        s_rd = rd_total; rd_value = 32'h0000_0013; ready_delay = 0;
        if_addr = 32'h8000_0000; if_req = 1'b1;
        wait_gnt(1'b0, 20, c);
        if_req = 1'b0;
        check("fetch_latency", c, 32'd2);
        check("fetch_read_cycles", rd_total - s_rd, 32'd1);
        check("fetch_rdata", o_if_rdata, 32'h0000_0013);
        step();

        // Store with three wait cycles; stray ready outside the access
        s_rd = rd_total; s_wr = wr_total; junk_ready = 1'b1; ready_delay = 3;
        d_we = 1'b1; d_addr = 32'h8000_1000; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
        wait_gnt(1'b1, 30, c);
        d_req = 1'b0; d_we = 1'b0;
        check("store_latency", c, 32'd5);
        check("store_write_cycles", wr_total - s_wr, 32'd4);
        check("store_read_cycles", rd_total - s_rd, 32'd0);
        check("store_addr", o_mem_addr, 32'h8000_1000);
        check("store_wdata", o_mem_wdata, 32'hDEAD_BEEF);
        check("store_d_rdata", o_d_rdata, 32'd0);
        check("store_no_err", {31'd0, o_bus_err}, 32'd0);
        junk_ready = 1'b0;
        step();

        // Both requesters held: data wins four times, then fetch
        rd_value = 32'h0000_1111; ready_delay = 0;
        if_addr = 32'h8000_0100; d_addr = 32'h8000_3000; d_we = 1'b0;
        g0 = gnt_log.size(); grants = 0; c = 0;
        if_req = 1'b1; d_req = 1'b1;
        while (grants < 10 && c < 60) begin
            step();
            c++;
            if (o_if_gnt || o_d_gnt) grants++;
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (3) step();
        check("arb_grant_count", gnt_log.size() - g0, 32'd10);
        order = '0;
        for (int i = 0; i < 10; i++) begin
            if (g0 + i < gnt_log.size()) order[9-i] = gnt_log[g0+i];
        end
        check("arb_order_DDDDIDDDDI", {22'd0, order}, 32'h0000_03DE);

        // Load timeout
        s_rd = rd_total; ready_delay = -1;
        d_we = 1'b0; d_addr = 32'h8000_2000; d_req = 1'b1;
        wait_gnt(1'b1, 40, c);
        check("timeout_err_with_gnt", {31'd0, o_bus_err}, 32'd1);
        d_req = 1'b0;
        check("timeout_latency", c, 32'd16);
        check("timeout_strobe_cycles", rd_total - s_rd, 32'd15);
        want_pattern = '1;
        check("timeout_d_rdata", o_d_rdata, want_pattern);
        step();
        check("timeout_err_pulse", {31'd0, o_bus_err}, 32'd0);

        // Asynchronous reset in the middle of an access
        ready_delay = -1; if_addr = 32'h8000_0200; if_req = 1'b1;
        c = 0;
        while (!o_mem_read && c < 5) begin
            step();
            c++;
        end
        check("midrst_access_started", {31'd0, o_mem_read}, 32'd1);
        g0 = gnt_log.size();
        #1;
        nreset = 1'b0;
        #1;
        check("midrst_strobes_gnts", {27'd0, o_mem_read, o_mem_write, o_if_gnt, o_d_gnt, o_bus_err}, 32'd0);
        check("midrst_mem_addr", o_mem_addr, 32'd0);
        check("midrst_if_rdata", o_if_rdata, 32'd0);
        check("midrst_d_rdata", o_d_rdata, 32'd0);
        if_req = 1'b0;
        step();
        nreset = 1'b1;
        repeat (3) step();
        check("midrst_no_grant", gnt_log.size() - g0, 32'd0);
        rd_value = 32'h0000_2222; ready_delay = 1; if_req = 1'b1;
        wait_gnt(1'b0, 20, c);
        if_req = 1'b0;
        check("postrst_latency", c, 32'd3);
        check("postrst_rdata", o_if_rdata, 32'h0000_2222);
        step();

        // Fetch request held through the grant with a new address
        a0 = acc_q.size(); rd_value = 32'h0000_3333; ready_delay = 0;
        if_addr = 32'h8000_0000; if_req = 1'b1;
        wait_gnt(1'b0, 20, c);
        check("held_first_rdata", o_if_rdata, 32'h0000_3333);
        if_addr = 32'h8000_0004; rd_value = 32'h0000_4444;
        wait_gnt(1'b0, 20, c);
        if_req = 1'b0;
        check("held_second_latency", c, 32'd3);
        check("held_second_rdata", o_if_rdata, 32'h0000_4444);
        repeat (4) step();
        check("held_access_count", acc_q.size() - a0, 32'd2);
        if (acc_q.size() >= a0 + 2) begin
            check("held_first_addr", acc_q[a0], 32'h8000_0000);
            check("held_second_addr", acc_q[a0+1], 32'h8000_0004);
        end

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
